// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: one holding slot per source (mem/mul/alu), round-robin grant
// into registered regfile write port, plus in-flight hazard query. Option: WB_R0_DISCARD_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef REG_FILE_WIDTH
`define REG_FILE_WIDTH 32
`endif

module regfile_wb_arbiter (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    input  logic                       mul_valid,
    input  logic                       alu_valid,
    input  logic [`ADDR_WIDTH-1:0]     mem_addr,
    input  logic [`ADDR_WIDTH-1:0]     mul_addr,
    input  logic [`ADDR_WIDTH-1:0]     alu_addr,
    input  logic [`REG_FILE_WIDTH-1:0] mem_data,
    input  logic [`REG_FILE_WIDTH-1:0] mul_data,
    input  logic [`REG_FILE_WIDTH-1:0] alu_data,
    output logic                       mem_ready,
    output logic                       mul_ready,
    output logic                       alu_ready,
    output logic                       wrt,
    output logic [`ADDR_WIDTH-1:0]     addrD,
    output logic [`REG_FILE_WIDTH-1:0] d,
    input  logic [`ADDR_WIDTH-1:0]     qaddr_a,
    input  logic [`ADDR_WIDTH-1:0]     qaddr_b,
    output logic                       pend_a,
    output logic                       pend_b
);

    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `REG_FILE_WIDTH;

    // rr pointer values double as slot indices
    localparam logic [1:0] SRC_MEM = 2'd0;
    localparam logic [1:0] SRC_MUL = 2'd1;
    localparam logic [1:0] SRC_ALU = 2'd2;

    logic [2:0]    req_valid;
    logic [AW-1:0] req_addr [3];
    logic [DW-1:0] req_data [3];

    logic [2:0]    slot_valid;
    logic [AW-1:0] slot_addr [3];
    logic [DW-1:0] slot_data [3];
    logic [1:0]    rr;

    logic [2:0]    grant;
    logic [1:0]    grant_idx;
    logic          grant_any;
    logic [2:0]    ready;
    logic [2:0]    accept;
    logic [2:0]    load;

    assign req_valid   = {alu_valid, mul_valid, mem_valid};
    assign req_addr[0] = mem_addr;
    assign req_addr[1] = mul_addr;
    assign req_addr[2] = alu_addr;
    assign req_data[0] = mem_data;
    assign req_data[1] = mul_data;
    assign req_data[2] = alu_data;

    always_comb begin
        grant_idx = SRC_MEM;
        grant_any = 1'b0;
        case (rr)
            SRC_MUL: begin
                if (slot_valid[1])      begin grant_idx = SRC_MUL; grant_any = 1'b1; end
                else if (slot_valid[2]) begin grant_idx = SRC_ALU; grant_any = 1'b1; end
                else if (slot_valid[0]) begin grant_idx = SRC_MEM; grant_any = 1'b1; end
            end
            SRC_ALU: begin
                if (slot_valid[2])      begin grant_idx = SRC_ALU; grant_any = 1'b1; end
                else if (slot_valid[0]) begin grant_idx = SRC_MEM; grant_any = 1'b1; end
                else if (slot_valid[1]) begin grant_idx = SRC_MUL; grant_any = 1'b1; end
            end
            default: begin
                if (slot_valid[0])      begin grant_idx = SRC_MEM; grant_any = 1'b1; end
                else if (slot_valid[1]) begin grant_idx = SRC_MUL; grant_any = 1'b1; end
                else if (slot_valid[2]) begin grant_idx = SRC_ALU; grant_any = 1'b1; end
            end
        endcase
        grant = grant_any ? (3'b001 << grant_idx) : 3'b000;
    end

    assign ready  = ~slot_valid | grant;
    assign accept = req_valid & ready;

    // Register-0 writes may be swallowed: handshake completes but nothing is queued
    always_comb begin
        load = accept;
`ifdef WB_R0_DISCARD_EN
        for (int i = 0; i < 3; i++) begin
            if (req_addr[i] == '0) load[i] = 1'b0;
        end
`endif
    end

    assign mem_ready = ready[0];
    assign mul_ready = ready[1];
    assign alu_ready = ready[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            for (int i = 0; i < 3; i++) begin
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_addr[i]  <= req_addr[i];
                    slot_data[i]  <= req_data[i];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= SRC_MEM;
        end else if (grant_any) begin
            case (grant_idx)
                SRC_MEM: rr <= SRC_MUL;
                SRC_MUL: rr <= SRC_ALU;
                default: rr <= SRC_MEM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrt   <= 1'b0;
            addrD <= '0;
            d     <= '0;
        end else begin
            wrt <= grant_any;
            if (grant_any) begin
                addrD <= slot_addr[grant_idx];
                d     <= slot_data[grant_idx];
            end
        end
    end

    always_comb begin
        pend_a = wrt && (addrD == qaddr_a);
        pend_b = wrt && (addrD == qaddr_b);
        for (int i = 0; i < 3; i++) begin
            if (slot_valid[i] && (slot_addr[i] == qaddr_a)) pend_a = 1'b1;
            if (slot_valid[i] && (slot_addr[i] == qaddr_b)) pend_b = 1'b1;
        end
`ifdef WB_R0_DISCARD_EN
        if (qaddr_a == '0) pend_a = 1'b0;
        if (qaddr_b == '0) pend_b = 1'b0;
`endif
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: expected writes queued at stimulus time, popped
// when wrt is seen; scenario tasks add inline timing/ready/pending checks.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef REG_FILE_WIDTH
`define REG_FILE_WIDTH 32
`endif

module tb_regfile_wb_arbiter;

    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `REG_FILE_WIDTH;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] v;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_valid = 0, mul_valid = 0, alu_valid = 0;
    logic [AW-1:0] mem_addr = '0, mul_addr = '0, alu_addr = '0;
    logic [DW-1:0] mem_data = '0, mul_data = '0, alu_data = '0;
    logic          mem_ready, mul_ready, alu_ready;
    logic          wrt;
    logic [AW-1:0] addrD;
    logic [DW-1:0] d;
    logic [AW-1:0] qaddr_a = '0, qaddr_b = '0;
    logic          pend_a, pend_b;

    exp_t exp_q[$];
    int   tests_run  = 0;
    int   fail_count = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mul_valid(mul_valid), .alu_valid(alu_valid),
        .mem_addr(mem_addr), .mul_addr(mul_addr), .alu_addr(alu_addr),
        .mem_data(mem_data), .mul_data(mul_data), .alu_data(alu_data),
        .mem_ready(mem_ready), .mul_ready(mul_ready), .alu_ready(alu_ready),
        .wrt(wrt), .addrD(addrD), .d(d),
        .qaddr_a(qaddr_a), .qaddr_b(qaddr_b),
        .pend_a(pend_a), .pend_b(pend_b)
    );

    // Scoreboard: every observed write must match the oldest expected one
    always @(negedge clk) begin
        if (!rst && wrt) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fail_count++;
                $display("FAIL sb_unexpected: got write addr %0d data %0h, expected no write", addrD, d);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (addrD !== e.a || d !== e.v) begin
                    fail_count++;
                    $display("FAIL sb_write: got addr %0d data %0h, expected addr %0d data %0h",
                             addrD, d, e.a, e.v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        tests_run++;
        if ({wrt, addrD, d} !== '0) begin
            fail_count++;
            $display("FAIL reset_outputs: got wrt %b addrD %0d d %0h, expected all 0", wrt, addrD, d);
        end
        tests_run++;
        if ({alu_ready, mul_ready, mem_ready} !== 3'b111) begin
            fail_count++;
            $display("FAIL reset_ready: got %b expected 111", {alu_ready, mul_ready, mem_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({alu_ready, mul_ready, mem_ready} !== 3'b111 || wrt !== 1'b0) begin
            fail_count++;
            $display("FAIL post_reset: got ready %b wrt %b expected ready 111 wrt 0",
                     {alu_ready, mul_ready, mem_ready}, wrt);
        end
    endtask

    task automatic test_single_alu();
        apply_reset();
        alu_valid = 1'b1; alu_addr = 3; alu_data = 32'hDEADBEEF;
        exp_q.push_back('{a: AW'(3), v: DW'(32'hDEADBEEF)});
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (wrt !== 1'b0) begin
            fail_count++;
            $display("FAIL single_early: got wrt %b expected 0", wrt);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (wrt !== 1'b1 || addrD !== AW'(3) || d !== DW'(32'hDEADBEEF)) begin
            fail_count++;
            $display("FAIL single_write: got wrt %b addrD %0d d %0h expected 1 3 deadbeef", wrt, addrD, d);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (wrt !== 1'b0 || addrD !== AW'(3) || d !== DW'(32'hDEADBEEF)) begin
            fail_count++;
            $display("FAIL single_hold: got wrt %b addrD %0d d %0h expected 0 3 deadbeef", wrt, addrD, d);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fail_count++;
            $display("FAIL single_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        mem_valid = 1; mem_addr = 1; mem_data = 32'hAAAA0001;
        mul_valid = 1; mul_addr = 2; mul_data = 32'hBBBB0002;
        alu_valid = 1; alu_addr = 3; alu_data = 32'hCCCC0003;
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back('{a: AW'(1), v: DW'(32'hAAAA0001)});
            exp_q.push_back('{a: AW'(2), v: DW'(32'hBBBB0002)});
            exp_q.push_back('{a: AW'(3), v: DW'(32'hCCCC0003)});
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 7) begin
                mem_valid = 0; mul_valid = 0; alu_valid = 0;
            end
            @(negedge clk);
            tests_run++;
            if ({alu_ready, mul_ready, mem_ready} !== (3'b001 << ((k - 1) % 3))) begin
                fail_count++;
                $display("FAIL rr_ready cycle %0d: got %b expected %b", k,
                         {alu_ready, mul_ready, mem_ready}, 3'b001 << ((k - 1) % 3));
            end
            if (k >= 2) begin
                tests_run++;
                if (wrt !== 1'b1) begin
                    fail_count++;
                    $display("FAIL rr_wrt cycle %0d: got %b expected 1", k, wrt);
                end
            end
        end
        repeat (4) tick();
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0 || wrt !== 1'b0) begin
            fail_count++;
            $display("FAIL rr_drain: got %0d pending wrt %b expected 0 pending wrt 0", exp_q.size(), wrt);
        end
    endtask

    task automatic test_pending();
        apply_reset();
        qaddr_a = 7; qaddr_b = 8;
        mem_valid = 1; mem_addr = 7; mem_data = 32'h00007777;
        exp_q.push_back('{a: AW'(7), v: DW'(32'h00007777)});
        #1;
        tests_run++;
        if (pend_a !== 1'b0) begin
            fail_count++;
            $display("FAIL pend_before: got %b expected 0", pend_a);
        end
        tick();
        mem_valid = 0;
        @(negedge clk);
        tests_run++;
        if (pend_a !== 1'b1 || pend_b !== 1'b0) begin
            fail_count++;
            $display("FAIL pend_slot: got a %b b %b expected a 1 b 0", pend_a, pend_b);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (pend_a !== 1'b1 || pend_b !== 1'b0 || wrt !== 1'b1 || addrD !== AW'(7)) begin
            fail_count++;
            $display("FAIL pend_wrt: got a %b b %b wrt %b addrD %0d expected 1 0 1 7", pend_a, pend_b, wrt, addrD);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (pend_a !== 1'b0 || pend_b !== 1'b0) begin
            fail_count++;
            $display("FAIL pend_clear: got a %b b %b expected 0 0", pend_a, pend_b);
        end
        qaddr_a = 0; qaddr_b = 0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        qaddr_a = 5;
        mul_valid = 1; mul_addr = 5; mul_data = 32'h00005555;
        tick();
        mul_data = 32'h00005556;
        tick();
        mul_valid = 0;
        tests_run++;
        if (wrt !== 1'b1 || addrD !== AW'(5)) begin
            fail_count++;
            $display("FAIL mid_prewrite: got wrt %b addrD %0d expected 1 5", wrt, addrD);
        end
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({wrt, addrD, d} !== '0 || pend_a !== 1'b0 || mul_ready !== 1'b1) begin
            fail_count++;
            $display("FAIL mid_reset: got wrt %b addrD %0d d %0h pend %b ready %b expected 0 0 0 0 1",
                     wrt, addrD, d, pend_a, mul_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (wrt !== 1'b0) begin
                fail_count++;
                $display("FAIL mid_nowrite cycle %0d: got wrt %b addrD %0d expected wrt 0", k, wrt, addrD);
            end
            tick();
        end
        qaddr_a = 0;
    endtask

    task automatic test_r0();
        apply_reset();
        qaddr_a = 0;
        alu_valid = 1; alu_addr = 0; alu_data = 32'h1;
`ifdef WB_R0_DISCARD_EN
        #1;
        tests_run++;
        if (alu_ready !== 1'b1) begin
            fail_count++;
            $display("FAIL r0_ready: got %b expected 1", alu_ready);
        end
        tick();
        alu_valid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (wrt !== 1'b0 || pend_a !== 1'b0) begin
                fail_count++;
                $display("FAIL r0_discard cycle %0d: got wrt %b pend %b expected 0 0", k, wrt, pend_a);
            end
            tick();
        end
`else
        exp_q.push_back('{a: AW'(0), v: DW'(32'h1)});
        tick();
        alu_valid = 0;
        @(negedge clk);
        tests_run++;
        if (pend_a !== 1'b1) begin
            fail_count++;
            $display("FAIL r0_pend: got %b expected 1", pend_a);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (wrt !== 1'b1 || addrD !== AW'(0)) begin
            fail_count++;
            $display("FAIL r0_write: got wrt %b addrD %0d expected 1 0", wrt, addrD);
        end
        tick();
`endif
        tests_run++;
        if (exp_q.size() != 0) begin
            fail_count++;
            $display("FAIL r0_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_alu_stream();
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            alu_valid = 1; alu_addr = 4; alu_data = 32'h50000000 + k;
            exp_q.push_back('{a: AW'(4), v: DW'(32'h50000000 + k)});
            tick();
            @(negedge clk);
            tests_run++;
            if (alu_ready !== 1'b1) begin
                fail_count++;
                $display("FAIL stream_ready step %0d: got %b expected 1", k, alu_ready);
            end
            if (k >= 1) begin
                tests_run++;
                if (wrt !== 1'b1 || d !== DW'(32'h50000000 + k - 1)) begin
                    fail_count++;
                    $display("FAIL stream_lag step %0d: got wrt %b d %0h expected 1 %0h",
                             k, wrt, d, 32'h50000000 + k - 1);
                end
            end
        end
        alu_valid = 0;
        repeat (3) tick();
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0 || wrt !== 1'b0) begin
            fail_count++;
            $display("FAIL stream_drain: got %0d pending wrt %b expected 0 pending wrt 0", exp_q.size(), wrt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_alu();
        test_round_robin();
        test_pending();
        test_reset_mid();
        test_r0();
        test_alu_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
